// File: rtl/core_pkg.sv
// Shared definitions for the 16-bit core pipeline.
// Opcodes, ALU control encodings and the decoded-control bundle.
package core_pkg;

    localparam logic [3:0] OP_HOLD = 4'b0000;
    localparam logic [3:0] OP_HALT = 4'b0001;
    localparam logic [3:0] OP_JMP  = 4'b0010;
    localparam logic [3:0] OP_BR   = 4'b0100;
    localparam logic [3:0] OP_ST   = 4'b0111;
    localparam logic [3:0] OP_LD   = 4'b1000;
    localparam logic [3:0] OP_ALUR = 4'b1010;
    localparam logic [3:0] OP_ALUF = 4'b1011;
    localparam logic [3:0] OP_IMM0 = 4'b1100;
    localparam logic [3:0] OP_IMM1 = 4'b1101;
    localparam logic [3:0] OP_IMM2 = 4'b1110;
    localparam logic [3:0] OP_IMM3 = 4'b1111;

    localparam logic [3:0] ALU_IMM0 = 4'b0000;
    localparam logic [3:0] ALU_IMM1 = 4'b0001;
    localparam logic [3:0] ALU_IMM2 = 4'b0010;
    localparam logic [3:0] ALU_IMM3 = 4'b0011;
    localparam logic [3:0] ALU_FNUL = 4'b1000;
    localparam logic [3:0] ALU_NONE = 4'b0000;

    typedef struct packed {
        logic       write_en;
        logic       mem_write;
        logic       mem_read;
        logic       jmp_br;
        logic       rdrq_or_imm;
        logic       rs_or_imm;
        logic [2:0] write_reg;
        logic [2:0] rs;
        logic [2:0] rdrq;
        logic [3:0] alu_ctrl;
    } ctrl_t;

endpackage

// File: rtl/decode_ctrl.sv
// Combinational instruction decoder.
// Produces the control bundle and operand-use flags.
module decode_ctrl
    import core_pkg::*;
#(
    parameter int INST_W = 16
) (
    input  logic [INST_W-1:0] inst,
    output ctrl_t             ctrl,
    output logic              rs_used,
    output logic              rq_used
);

    logic [3:0] op;
    logic [2:0] func;

    assign op   = inst[INST_W-1 -: 4];
    assign func = inst[2:0];

    // Field extraction, control bits and ALU control selection
    always_comb begin
        ctrl             = '0;
        ctrl.write_en    = inst[INST_W-1];
        ctrl.mem_write   = (op == OP_ST);
        ctrl.mem_read    = (op == OP_LD);
        ctrl.jmp_br      = (op == OP_JMP) || (op == OP_BR);
        ctrl.rdrq_or_imm = (op == OP_ST) || (op == OP_LD);
        ctrl.rs_or_imm   = inst[INST_W-3];
        ctrl.write_reg   = inst[11:9];
        ctrl.rs          = inst[8:6];
        ctrl.rdrq        = inst[INST_W-2] ? inst[11:9] : inst[5:3];
        rs_used = !((op == OP_HOLD) || (op == OP_HALT) || (op == OP_JMP));
        rq_used = (op == OP_BR) || (op == OP_ST) ||
                  (op == OP_ALUR) || (op == OP_ALUF);
        unique case (1'b1)
            (op == OP_IMM0): ctrl.alu_ctrl = ALU_IMM0;
            (op == OP_IMM1): ctrl.alu_ctrl = ALU_IMM1;
            (op == OP_IMM2): ctrl.alu_ctrl = ALU_IMM2;
            (op == OP_IMM3): ctrl.alu_ctrl = ALU_IMM3;
            (op == OP_ALUF): ctrl.alu_ctrl = (func != 3'b000) ?
                                             {1'b0, func} : ALU_FNUL;
            (op == OP_ALUR): ctrl.alu_ctrl = {1'b1, func};
            default:         ctrl.alu_ctrl = ALU_NONE;
        endcase
    end

endmodule

// File: rtl/decode_stage_pipe.sv
// Registered decode stage with load-use interlock,
// branch flush, sticky halt and a saturating bubble counter.
module decode_stage_pipe
    import core_pkg::*;
#(
    parameter int PC_W      = 13,
    parameter int INST_W    = 16,
    parameter bit HAZARD_EN = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [PC_W-1:0]   in_pc_plus1,
    input  logic [INST_W-1:0] in_inst,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [INST_W-1:0] out_inst,
    output logic [2:0]        out_rdrq,
    output logic [2:0]        out_rs,
    output logic [2:0]        out_write_reg,
    output logic              out_write_en,
    output logic              out_mem_write,
    output logic              out_mem_read,
    output logic              out_jmp_br,
    output logic              out_rdrq_or_imm,
    output logic              out_rs_or_imm,
    output logic [3:0]        out_alu_ctrl,
    output logic              halted,
    output logic [CNT_W-1:0]  bubble_cnt
);

    ctrl_t      dec;
    ctrl_t      q;
    logic       rs_used;
    logic       rq_used;
    logic [3:0] op;
    logic       hazard;
    logic       accept;

    decode_ctrl #(.INST_W(INST_W)) u_dec (
        .inst    (in_inst),
        .ctrl    (dec),
        .rs_used (rs_used),
        .rq_used (rq_used)
    );

    assign op = in_inst[INST_W-1 -: 4];

    // Load-use interlock; a flush overrides it
    always_comb begin
        hazard = HAZARD_EN && !flush && out_valid && q.mem_read &&
                 in_valid &&
                 ((rs_used && (dec.rs == q.write_reg)) ||
                  (rq_used && (dec.rdrq == q.write_reg)));
    end

    assign in_ready = flush ||
                      (!halted && !hazard && (!out_valid || out_ready));
    assign accept   = in_valid && in_ready && !flush;

    // ID/EX register, halt flag and bubble counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            q          <= '0;
            out_pc     <= '0;
            out_inst   <= '0;
            halted     <= 1'b0;
            bubble_cnt <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                q         <= dec;
                out_inst  <= in_inst;
                out_pc    <= (op == OP_HOLD) ? in_pc : in_pc_plus1;
                if (op == OP_HALT) halted <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (hazard && out_ready && (bubble_cnt != '1))
                bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

    assign out_write_en    = q.write_en;
    assign out_mem_write   = q.mem_write;
    assign out_mem_read    = q.mem_read;
    assign out_jmp_br      = q.jmp_br;
    assign out_rdrq_or_imm = q.rdrq_or_imm;
    assign out_rs_or_imm   = q.rs_or_imm;
    assign out_write_reg   = q.write_reg;
    assign out_rs          = q.rs;
    assign out_rdrq        = q.rdrq;
    assign out_alu_ctrl    = q.alu_ctrl;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Self-checking bench for decode_stage_pipe.
// Directed scenarios plus random traffic against a reference model.
module tb_decode_stage_pipe;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        in_valid = 0, flush = 0, out_ready = 0;
    logic [12:0] in_pc = 0, in_pc_plus1 = 0;
    logic [15:0] in_inst = 0;

    logic        in_ready, out_valid, halted;
    logic [12:0] out_pc;
    logic [15:0] out_inst, bubble_cnt;
    logic [2:0]  out_rdrq, out_rs, out_write_reg;
    logic        out_write_en, out_mem_write, out_mem_read;
    logic        out_jmp_br, out_rdrq_or_imm, out_rs_or_imm;
    logic [3:0]  out_alu_ctrl;

    logic        in_ready0, out_valid0, halted0;
    logic [12:0] out_pc0;
    logic [15:0] out_inst0, bubble_cnt0;
    logic [2:0]  out_rdrq0, out_rs0, out_write_reg0;
    logic        out_write_en0, out_mem_write0, out_mem_read0;
    logic        out_jmp_br0, out_rdrq_or_imm0, out_rs_or_imm0;
    logic [3:0]  out_alu_ctrl0;

    int total = 0;
    int bad = 0;

    // reference model state
    logic        m_v, m_h;
    int          m_cnt;
    logic [15:0] m_inst;
    logic [12:0] m_pc;
    logic [18:0] m_f;

    always #5 clk = ~clk;

    decode_stage_pipe #(.HAZARD_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_ready(in_ready), .in_pc(in_pc),
        .in_pc_plus1(in_pc_plus1), .in_inst(in_inst),
        .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc),
        .out_inst(out_inst), .out_rdrq(out_rdrq),
        .out_rs(out_rs), .out_write_reg(out_write_reg),
        .out_write_en(out_write_en),
        .out_mem_write(out_mem_write),
        .out_mem_read(out_mem_read), .out_jmp_br(out_jmp_br),
        .out_rdrq_or_imm(out_rdrq_or_imm),
        .out_rs_or_imm(out_rs_or_imm),
        .out_alu_ctrl(out_alu_ctrl), .halted(halted),
        .bubble_cnt(bubble_cnt)
    );

    decode_stage_pipe #(.HAZARD_EN(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_ready(in_ready0), .in_pc(in_pc),
        .in_pc_plus1(in_pc_plus1), .in_inst(in_inst),
        .flush(flush), .out_valid(out_valid0),
        .out_ready(out_ready), .out_pc(out_pc0),
        .out_inst(out_inst0), .out_rdrq(out_rdrq0),
        .out_rs(out_rs0), .out_write_reg(out_write_reg0),
        .out_write_en(out_write_en0),
        .out_mem_write(out_mem_write0),
        .out_mem_read(out_mem_read0), .out_jmp_br(out_jmp_br0),
        .out_rdrq_or_imm(out_rdrq_or_imm0),
        .out_rs_or_imm(out_rs_or_imm0),
        .out_alu_ctrl(out_alu_ctrl0), .halted(halted0),
        .bubble_cnt(bubble_cnt0)
    );

    wire [18:0] obs_f = {out_write_en, out_mem_write,
                         out_mem_read, out_jmp_br,
                         out_rdrq_or_imm, out_rs_or_imm,
                         out_write_reg, out_rs, out_rdrq,
                         out_alu_ctrl};

    function automatic logic [18:0] ref_dec(input logic [15:0] i);
        int op = int'(i[15:12]);
        int f  = int'(i[2:0]);
        int alu;
        logic [2:0] rq;
        logic [3:0] a;
        if (op >= 12)      alu = op - 12;
        else if (op == 11) alu = (f != 0) ? f : 8;
        else if (op == 10) alu = 8 + f;
        else               alu = 0;
        a  = 4'(alu);
        rq = i[14] ? i[11:9] : i[5:3];
        return {i[15], op == 7, op == 8, op == 2 || op == 4,
                op == 7 || op == 8, i[13],
                i[11:9], i[8:6], rq, a};
    endfunction

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [12:0] pc,
                         input logic [15:0] inst,
                         input logic ordy, input logic fl);
        in_valid    = v;
        in_pc       = pc;
        in_pc_plus1 = pc + 13'd1;
        in_inst     = inst;
        out_ready   = ordy;
        flush       = fl;
    endtask

    task automatic check_out();
        chk("out_valid", 32'(out_valid), 32'(m_v));
        chk("halted", 32'(halted), 32'(m_h));
        chk("bubble_cnt", 32'(bubble_cnt), 32'(m_cnt));
        if (m_v) begin
            chk("fields", 32'(obs_f), 32'(m_f));
            chk("out_pc", 32'(out_pc), 32'(m_pc));
            chk("out_inst", 32'(out_inst), 32'(m_inst));
        end
    endtask

    task automatic step();
        int   io, mo;
        logic ru, qu, haz, rdy;
        logic [2:0] rq;
        @(negedge clk);
        io  = int'(in_inst[15:12]);
        mo  = int'(m_inst[15:12]);
        ru  = !(io inside {0, 1, 2});
        qu  = io inside {4, 7, 10, 11};
        rq  = in_inst[14] ? in_inst[11:9] : in_inst[5:3];
        haz = !flush && m_v && mo == 8 && in_valid &&
              ((ru && in_inst[8:6] == m_inst[11:9]) ||
               (qu && rq == m_inst[11:9]));
        rdy = flush || (!m_h && !haz && (!m_v || out_ready));
        chk("in_ready", 32'(in_ready), 32'(rdy));
        @(posedge clk);
        if (flush) begin
            m_v = 0;
        end else begin
            if (in_valid && rdy) begin
                m_v    = 1;
                m_inst = in_inst;
                m_f    = ref_dec(in_inst);
                m_pc   = (io == 0) ? in_pc : in_pc_plus1;
                if (io == 1) m_h = 1;
            end else if (out_ready) begin
                m_v = 0;
            end
            if (haz && out_ready && m_cnt < 65535) m_cnt++;
        end
        #1;
        check_out();
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0);
        rst_n = 0;
        #1;
        m_v = 0; m_h = 0; m_cnt = 0;
        m_inst = 0; m_pc = 0; m_f = 0;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_cnt", 32'(bubble_cnt), 0);
        chk("rst_fields", 32'(obs_f), 0);
        chk("rst_pc", 32'(out_pc), 0);
        chk("rst_inst", 32'(out_inst), 0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        chk("rst_ready", 32'(in_ready), 1);
    endtask

    initial begin
        logic [3:0] op;
        do_reset();

        // ADD r?, func 001
        drive(1, 13'h100, 16'hA001, 1, 0);
        step();
        chk("add_alu", 32'(out_alu_ctrl), 32'h9);
        chk("add_we", 32'(out_write_en), 1);
        chk("add_pc", 32'(out_pc), 32'h101);
        chk("add_valid", 32'(out_valid), 1);

        // load-use: LD r2 then ALUF reading r2
        drive(1, 13'h200, 16'h8400, 1, 0);
        step();
        drive(1, 13'h201, 16'hB081, 1, 0);
        #2;
        chk("ld_ready_h", 32'(in_ready), 0);
        chk("ld_ready_nh", 32'(in_ready0), 1);
        step();
        chk("ld_bubble", 32'(out_valid), 0);
        chk("ld_cnt", 32'(bubble_cnt), 1);
        chk("nh_valid", 32'(out_valid0), 1);
        chk("nh_inst", 32'(out_inst0), 32'hB081);
        step();
        chk("ld_issue", 32'(out_inst), 32'hB081);
        chk("ld_cnt2", 32'(bubble_cnt), 1);
        chk("nh_cnt", 32'(bubble_cnt0), 0);

        // back-pressure stall
        drive(1, 13'h300, 16'hC248, 1, 0);
        step();
        drive(1, 13'h301, 16'hD111, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_inst", 32'(out_inst), 32'hC248);
            chk("stall_ready", 32'(in_ready), 0);
        end
        out_ready = 1;
        step();
        chk("stall_next", 32'(out_inst), 32'hD111);

        // flush kills output and input
        drive(1, 13'h400, 16'hE000, 1, 1);
        step();
        chk("flush_valid", 32'(out_valid), 0);
        chk("flush_cnt", 32'(bubble_cnt), 1);

        // ALUF func 000 and HOLD pc
        drive(1, 13'h500, 16'hB000, 1, 0);
        step();
        chk("func0_alu", 32'(out_alu_ctrl), 32'h8);
        drive(1, 13'h600, 16'h0123, 1, 0);
        step();
        chk("hold_pc", 32'(out_pc), 32'h600);

        // HALT together with flush is ignored
        drive(1, 13'h700, 16'h1000, 1, 1);
        step();
        chk("halt_flush", 32'(halted), 0);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'b0001) op = 4'b1000;
            drive($urandom_range(0, 3) != 0,
                  13'($urandom),
                  {op, 1'b0, 2'($urandom), 1'b0, 2'($urandom),
                   1'b0, 2'($urandom), 3'($urandom)},
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 15) == 0);
            step();
        end
        chk("rnd_cnt_live", 32'(bubble_cnt > 0), 1);

        // HALT: sticky until reset
        drive(0, 0, 0, 1, 0);
        step();
        step();
        drive(1, 13'h0AA, 16'h1000, 1, 0);
        step();
        chk("halt_set", 32'(halted), 1);
        chk("halt_issue", 32'(out_valid), 1);
        drive(1, 13'h0AB, 16'hC000, 1, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("halt_ready", 32'(in_ready), 0);
        end
        do_reset();
        chk("post_halt", 32'(halted), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_stage_pipe.md
Name: decode_stage_pipe

Overview:
- Parametrised, registered successor to the combinational instruction decoder of the 16-bit core.
- Sits between fetch (IF/ID) and execute (ID/EX). Decodes the 4-bit opcode into control signals and latches them into an ID/EX output register with valid/ready flow control.
- Adds load-use hazard bubbles, branch flush, sticky halt and a saturating bubble counter.

Parameters:
- PC_W, 13, PC width.
- INST_W, 16, instruction width; opcode is the top 4 bits, register fields are at bits [11:9], [8:6] and [5:3].
- HAZARD_EN, 1, 1 enables load-use interlock; 0 disables it, so no bubbles are inserted.
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_pc  in  PC_W  PC of the instruction.
- in_pc_plus1  in  PC_W  PC+1.
- in_inst  in  INST_W  instruction word.
- flush  in  1  branch/jump redirect; kills the input and the output register contents.
- out_valid  out  1  ID/EX register holds a valid op.
- out_ready  in  1  execute consumes the op.
- out_pc  out  PC_W  in_pc if opcode is 0000, else in_pc_plus1.
- out_inst  out  INST_W  registered instruction.
- out_rdrq, out_rs, out_write_reg  out  3 each  register numbers.
- out_write_en, out_mem_write, out_mem_read, out_jmp_br, out_rdrq_or_imm, out_rs_or_imm  out  1 each  control bits.
- out_alu_ctrl  out  4  ALU control.
- halted  out  1  sticky halt.
- bubble_cnt  out  CNT_W  number of hazard bubbles inserted.

Behaviour:
- Reset (asynchronous, rst_n=0): all out_* = 0, out_valid=0, halted=0, bubble_cnt=0.
- Decode, combinational from in_inst, op = in_inst[15:12]:
  - write_en = inst[15].
  - mem_write = (op==0111); mem_read = (op==1000).
  - jmp_br = op in {0010, 0100}.
  - rdrq_or_imm = op in {0111, 1000}.
  - rs_or_imm = inst[13].
  - write_reg = inst[11:9]; rs = inst[8:6].
  - rdrq = inst[14] ? inst[11:9] : inst[5:3].
- ALU control:
  - op 1100, 1101, 1110, 1111 -> 0000, 0001, 0010, 0011.
  - op 1011 -> {0, func} if func=inst[2:0] is nonzero, else 1000.
  - op 1010 -> {1, func}.
  - any other op -> 0000. No latched value is inferred.
- Operand use:
  - rs_used = op not in {0000, 0001, 0010}.
  - rq_used = op in {0100, 0111, 1010, 1011}.
- Hazard (HAZARD_EN=1): hazard = out_valid & out_mem_read & in_valid & ((rs_used & rs==out_write_reg) | (rq_used & rdrq==out_write_reg)).
- Flow control:
  - in_ready = !halted & !hazard & (!out_valid | out_ready).
  - Accept on in_valid & in_ready: register the decoded fields, out_valid=1, latency 1 cycle.
- Hazard with out_ready=1: the load leaves, out_valid becomes 0 (one bubble), the input is held, and bubble_cnt increments, saturating at all-ones. On the next cycle the input is accepted.
- Hazard with out_ready=0: plain stall, no count.
- Output valid and out_ready=0: all out_* hold stable.
- flush=1: out_valid clears next cycle. in_ready is forced to 1 so the input is consumed and discarded. No hazard bubble is counted, and halt is not latched. flush has priority over every other event.
- Halt: when an op=0001 instruction is accepted without flush, halted is set on the same edge and the op itself is issued. halted then forces in_ready=0 until reset; out_valid drains normally.
- Reset mid-operation clears everything immediately, including a pending bubble.

Decomposition:
- Shared package core_pkg:
  - opcode localparams: OP_HOLD=0000, OP_HALT=0001, OP_JMP=0010, OP_BR=0100, OP_ST=0111, OP_LD=1000, OP_ALUR=1010, OP_ALUF=1011, OP_IMM0..3=1100..1111.
  - ALU control encodings.
  - a decoded-control struct typedef.
- One sub-module, decode_ctrl: purely combinational, instruction to control struct. decode_stage_pipe owns the hazard logic, the registers, halt and the counter.

Test Plan:
- Reset, then stream ADD (op 1010, func 001) with out_ready=1 -> out_valid one cycle later; out_alu_ctrl=1001, write_en=1, out_pc=in_pc_plus1.
- LD r2 followed by op 1011 with rs=r2, out_ready=1 -> one cycle with out_valid=0, in_ready=0 on the consumer's first cycle, then the consumer is issued; bubble_cnt=1. Repeat with HAZARD_EN=0 -> no bubble, bubble_cnt=0.
- out_ready held 0 for 3 cycles with a valid op -> all out_* stable, in_ready=0, the next instruction is accepted the cycle out_ready rises.
- flush asserted while out_valid=1 and in_valid=1 -> out_valid=0 next cycle, the input is discarded, no count.
- HALT (0x1000) accepted -> halted=1 on the same edge, in_ready=0 forever after; reset restores in_ready=1 and halted=0.
- op 1011 with func=000 -> alu_ctrl=1000; op 0000 -> out_pc=in_pc; flush in the same cycle as HALT -> halted stays 0.
